// File: rtl/cache_data_in_arbiter.sv
// cache_data_in_arbiter
// Collects 32-bit words from three producers (SRAM1, SRAM2, AHB) and
// delivers them to the cache write port through a one-entry registered
// output stage. One producer at a time owns a fixed-length burst, and
// ownership rotates round-robin.
//
// Handshake: every channel uses strict valid/ready semantics. A word moves
// on the rising edge where valid and ready are both high. A producer must
// hold its word stable while valid is high and ready is low. Ready never
// depends on the same channel's valid.
//
// Source codes match the cache output steering: 1=SRAM1, 2=SRAM2, 3=AHB, 0=none.
//
// Optional feature: define CACHE_IN_ABORT_EN to add the burst_abort input.
// It ends the current grant early, without a burst_done pulse.
//
// dbg_state exposes the FSM state (0=IDLE, 1=GRANT).

module cache_data_in_arbiter #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sram1_valid,
    input  logic [DATA_W-1:0] sram1_data,
    output logic              sram1_ready,
    input  logic              sram2_valid,
    input  logic [DATA_W-1:0] sram2_data,
    output logic              sram2_ready,
    input  logic              ahb_valid,
    input  logic [DATA_W-1:0] ahb_data,
    output logic              ahb_ready,
    output logic              cache_valid,
    output logic [DATA_W-1:0] cache_data,
    output logic [1:0]        cache_src,
    input  logic              cache_ready,
    output logic              burst_done,
`ifdef CACHE_IN_ABORT_EN
    input  logic              burst_abort,
`endif
    output logic              dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_SRAM1 = 2'd1;
    localparam logic [1:0] SRC_SRAM2 = 2'd2;
    localparam logic [1:0] SRC_AHB   = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    state_t           state, state_n;
    logic [1:0]       grant, grant_n;
    logic [1:0]       last_grant, last_grant_n;
    logic [CNT_W-1:0] count, count_n;
    logic             done_n;
    logic [1:0]       pick;
    logic             src_valid;
    logic [DATA_W-1:0] src_data;
    logic             slot_free;
    logic             xfer;
    logic             abort_req;

`ifdef CACHE_IN_ABORT_EN
    assign abort_req = burst_abort;
`else
    assign abort_req = 1'b0;
`endif

    assign dbg_state = (state == GRANT);

    // Output slot can take a word when empty or being drained this cycle.
    assign slot_free = !cache_valid || cache_ready;

    // Round-robin pick: scan starts at the source after last_grant.
    always_comb begin
        pick = SRC_NONE;
        case (last_grant)
            SRC_SRAM1: begin
                if (sram2_valid)      pick = SRC_SRAM2;
                else if (ahb_valid)   pick = SRC_AHB;
                else if (sram1_valid) pick = SRC_SRAM1;
            end
            SRC_SRAM2: begin
                if (ahb_valid)        pick = SRC_AHB;
                else if (sram1_valid) pick = SRC_SRAM1;
                else if (sram2_valid) pick = SRC_SRAM2;
            end
            default: begin
                if (sram1_valid)      pick = SRC_SRAM1;
                else if (sram2_valid) pick = SRC_SRAM2;
                else if (ahb_valid)   pick = SRC_AHB;
            end
        endcase
    end

    // Route the granted producer's valid and data to the output stage.
    always_comb begin
        src_valid = 1'b0;
        src_data  = '0;
        case (grant)
            SRC_SRAM1: begin src_valid = sram1_valid; src_data = sram1_data; end
            SRC_SRAM2: begin src_valid = sram2_valid; src_data = sram2_data; end
            SRC_AHB:   begin src_valid = ahb_valid;   src_data = ahb_data;   end
            default:   begin src_valid = 1'b0;        src_data = '0;         end
        endcase
    end

    // FSM next state, burst bookkeeping and producer ready outputs.
    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        count_n      = count;
        done_n       = 1'b0;
        xfer         = 1'b0;
        sram1_ready  = 1'b0;
        sram2_ready  = 1'b0;
        ahb_ready    = 1'b0;
        case (state)
            IDLE: begin
                // Arbitration takes this whole cycle, so no word is accepted here.
                if (pick != SRC_NONE) begin
                    grant_n = pick;
                    count_n = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (abort_req) begin
                    // Abort ends the grant quietly; any held word still drains.
                    state_n      = IDLE;
                    last_grant_n = grant;
                    grant_n      = SRC_NONE;
                    count_n      = '0;
                end else begin
                    sram1_ready = (grant == SRC_SRAM1) && slot_free;
                    sram2_ready = (grant == SRC_SRAM2) && slot_free;
                    ahb_ready   = (grant == SRC_AHB)   && slot_free;
                    xfer        = src_valid && slot_free;
                    if (xfer) begin
                        if (count == LAST_CNT) begin
                            state_n      = IDLE;
                            last_grant_n = grant;
                            grant_n      = SRC_NONE;
                            count_n      = '0;
                            done_n       = 1'b1;
                        end else begin
                            count_n = count + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state register plus registered burst_done pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            grant      <= SRC_NONE;
            last_grant <= SRC_AHB;
            count      <= '0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            count      <= count_n;
            burst_done <= done_n;
        end
    end

    // One-entry output register: reload on transfer, otherwise clear when consumed.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cache_valid <= 1'b0;
            cache_data  <= '0;
            cache_src   <= SRC_NONE;
        end else if (xfer) begin
            cache_valid <= 1'b1;
            cache_data  <= src_data;
            cache_src   <= grant;
        end else if (cache_ready) begin
            cache_valid <= 1'b0;
            cache_src   <= SRC_NONE;
        end
    end

endmodule

// File: doc/cache_data_in_arbiter.md
Name: cache_data_in_arbiter

Overview:
- Inbound counterpart to the cache's outbound data steering.
- Collects 32-bit words from three producers (AHB slave, SRAM1 controller, SRAM2 controller) and delivers them to the cache write port.
- Grants one producer at a time for a fixed-length burst, using round-robin arbitration.
- Data passes through a one-entry registered output stage with a valid/ready handshake toward the cache.
- Reports the source of each word using the select encoding already used for cache output: 1=SRAM1, 2=SRAM2, 3=AHB.

Parameters:
- DATA_W, 32: width of every data bus.
- BURST_LEN, 4: words accepted per grant; legal range 1..16.
- CNT_W, 4: burst counter width; must satisfy 2^CNT_W >= BURST_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- sram1_valid  in  1  SRAM1 has a word.
- sram1_data  in  DATA_W  SRAM1 word.
- sram1_ready  out  1  SRAM1 word accepted this cycle when valid&ready.
- sram2_valid  in  1  SRAM2 has a word.
- sram2_data  in  DATA_W  SRAM2 word.
- sram2_ready  out  1  SRAM2 accept.
- ahb_valid  in  1  AHB has a word.
- ahb_data  in  DATA_W  AHB word.
- ahb_ready  out  1  AHB accept.
- cache_valid  out  1  output register holds a word.
- cache_data  out  DATA_W  word to cache.
- cache_src  out  2  source of cache_data: 1/2/3 as above; 0 when cache_valid=0.
- cache_ready  in  1  cache consumes the word when cache_valid&cache_ready.
- burst_done  out  1  one-cycle pulse after the last word of a burst is accepted.

Behaviour:
- Reset (n_rst=0, asynchronous) sets:
  - state=IDLE, grant=0, count=0, last_grant=3 (so SRAM1 has first priority).
  - cache_valid=0, cache_data=0, cache_src=0, burst_done=0.
  - All *_ready outputs=0.
- Reset mid-burst drops the burst and any held word without notice. Producers re-present the word after reset.
- FSM states: IDLE, GRANT.
- IDLE:
  - All *_ready=0.
  - If any *_valid is high, pick the first asserted source in the order following last_grant (cycle order SRAM1 -> SRAM2 -> AHB -> SRAM1).
  - Register the pick as grant, clear count, go to GRANT next cycle.
  - No request: stay in IDLE.
  - Arbitration costs exactly one cycle. It is never combinational in the same cycle as the first accept.
- GRANT:
  - Only the granted source's ready may be high: ready = (cache_valid==0) | cache_ready.
  - Non-granted ready outputs are 0.
  - A transfer occurs on granted valid&ready. That edge loads cache_data/cache_src, sets cache_valid=1 and increments count.
- Output register:
  - If cache_ready is high with no new transfer, cache_valid clears and cache_src returns to 0. cache_data holds its last value.
  - If a new transfer coincides with cache consumption, the register reloads and cache_valid stays 1. This gives full throughput of 1 word/cycle.
  - Latency from source accept to cache_valid is 1 cycle.
- Burst completion:
  - The transfer with count==BURST_LEN-1 ends the burst.
  - Next cycle: state=IDLE, burst_done=1 for one cycle, last_grant=grant, count=0.
- A granted source that drops valid mid-burst keeps the grant. The FSM waits indefinitely, with no timeout.
- The held word is never overwritten while cache_valid=1 and cache_ready=0.
- Simultaneous requests in IDLE are resolved by round-robin only. A source that requests continuously cannot starve the others for more than two bursts.
- BURST_LEN=1: each grant is one word, and arbitration occurs between every word.

Optional Feature:
- Macro: CACHE_IN_ABORT_EN.
- When defined:
  - Adds input burst_abort (1 bit).
  - burst_abort=1 in GRANT forces ready=0 that cycle and state=IDLE next cycle.
  - count=0, last_grant=grant, burst_done is not pulsed.
  - A word already in the output register still drains normally.
  - burst_abort in IDLE is ignored.
- When undefined: no port; bursts end only by count or reset.

Test Plan:
- SRAM1 alone, valid held high, data 0x11,0x12,0x13,0x14, cache_ready=1 -> cache_valid on 4 consecutive cycles with cache_src=1, data in order, burst_done pulse one cycle after last accept, then IDLE.
- All three valid continuously from reset, BURST_LEN=4 -> grant order SRAM1, SRAM2, AHB, SRAM1; cache_src sequence 1x4, 2x4, 3x4, 1x4.
- Backpressure: cache_ready=0 for 3 cycles during an AHB burst with data 0xA0.. -> ahb_ready=0 while full, cache_data holds 0xA0, no words lost or duplicated, order preserved.
- Granted SRAM2 drops valid after 2 words for 5 cycles; SRAM1 valid meanwhile -> SRAM1 ready stays 0, burst resumes and finishes 4 SRAM2 words before SRAM1 is granted.
- Assert n_rst=0 mid-burst with cache_valid=1 -> all outputs 0 immediately; after release, SRAM1 has first priority.
- With CACHE_IN_ABORT_EN: abort after 2nd SRAM1 word -> IDLE next cycle, no burst_done, next grant SRAM2 if requesting.
